cacheline_adaptor: RTL and testbench

- Responder on the cache's 256-bit physical-memory line interface.
- Converts each line read or line write into a 4-beat, 64-bit burst on the DRAM-side interface.
- Sits between the cache datapath/controller and the burst memory model.
- Handles one line transaction at a time, fully buffered; completion is signalled to the cache with a single-cycle response.

---
 rtl/cacheline_adaptor.sv | 128 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Cache line (256-bit) to DRAM burst (4 x 64-bit) adaptor.
// One buffered line transaction at a time; resp_o pulses once when the burst completes.
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    // Clears the byte offset within a line (low 5 bits for a 32-byte line).
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  line_buf;
    logic [ADDR_W-1:0]  addr;
    logic               last_beat;

    assign last_beat = resp_i && (cnt == CNT_W'(BEATS - 1));
    assign line_o    = line_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (write_i) begin
                    state_next = WR;
                end else if (read_i) begin
                    state_next = RD;
                end
            end
            RD:      if (last_beat) state_next = DONE;
            WR:      if (last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            line_buf <= '0;
            addr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        line_buf <= line_i;
                        addr     <= address_i & ADDR_MASK;
                        cnt      <= '0;
                    end else if (read_i) begin
                        addr     <= address_i & ADDR_MASK;
                        cnt      <= '0;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        for (int unsigned k = 0; k < BEATS; k++) begin
                            if (cnt == CNT_W'(k)) begin
                                line_buf[k*BURST_W +: BURST_W] <= burst_i;
                            end
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    if (resp_i) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        address_o = '0;
        burst_o   = '0;
        case (state)
            RD: begin
                read_o    = 1'b1;
                address_o = addr;
            end
            WR: begin
                write_o   = 1'b1;
                address_o = addr;
                for (int unsigned k = 0; k < BEATS; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        burst_o = line_buf[k*BURST_W +: BURST_W];
                    end
                end
            end
            DONE:    resp_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: request driver, DRAM responder/monitor with a scoreboard
// queue, and line-level reference memories for the cache view and the DRAM contents.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    always #5 clk = ~clk;

    cacheline_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } exp_t;

    exp_t         exp_q[$];
    logic [255:0] model [logic [31:0]];
    logic [255:0] dram  [logic [31:0]];
    int           total = 0;
    int           bad = 0;
    int           gap_mode = 0;   // 0: no gaps, 1: random gaps + spurious resp_i, 2: forced gap before beat 2
    int           gap_left = 0;
    int           rb = 0;
    bit           final_pending = 1'b0;
    bit           prev_resp = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] init_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = a ^ (32'h9E3779B9 * (i + 1));
        return l;
    endfunction

    function automatic logic [255:0] model_get(input logic [31:0] a);
        if (model.exists(a)) return model[a];
        return init_line(a);
    endfunction

    function automatic logic [255:0] dram_get(input logic [31:0] a);
        if (dram.exists(a)) return dram[a];
        return init_line(a);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // DRAM responder and scoreboard monitor
    always @(negedge clk) begin : resp_mon
        exp_t         e;
        bit           go;
        logic [255:0] d;
        if (!rst) begin
            rb            = 0;
            final_pending = 1'b0;
            prev_resp     = 1'b0;
            resp_i        = 1'b0;
        end else begin
            check("resp_timing", resp_o, final_pending);
            if (prev_resp) check("idle_after_done", {read_o, write_o}, 0);
            if (resp_o) begin
                check("queue_at_resp", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check(e.wr ? "wr_line_o" : "rd_line_o", line_o, e.line);
                end
            end
            prev_resp     = resp_o;
            final_pending = 1'b0;
            burst_i       = {$urandom, $urandom};
            if (read_o || write_o) begin
                check("queue_at_burst", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    check("burst_dir", {read_o, write_o}, e.wr ? 2'b01 : 2'b10);
                    check("address_o", address_o, e.addr);
                    if (write_o) check("burst_o", burst_o, e.line[rb*64 +: 64]);
                    case (gap_mode)
                        0: go = 1'b1;
                        2: begin
                            go = !(rb == 2 && gap_left > 0);
                            if (!go) gap_left--;
                        end
                        default: go = ($urandom_range(0, 2) != 0);
                    endcase
                    if (go) begin
                        d = dram_get(address_o);
                        if (write_o) begin
                            d[rb*64 +: 64] = burst_o;
                            dram[address_o] = d;
                        end else begin
                            burst_i = d[rb*64 +: 64];
                        end
                        if (rb == 3) final_pending = 1'b1;
                        rb = (rb + 1) % 4;
                    end
                    resp_i = go;
                end else begin
                    resp_i = 1'b0;
                end
            end else begin
                check("address_o_idle", address_o, 0);
                check("burst_o_idle", burst_o, 0);
                resp_i = (gap_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    task automatic txn(input bit wr, input bit rd, input logic [31:0] a, input logic [255:0] l,
                       input bit scramble, output int lat1, output int lat2);
        exp_t        e;
        logic [31:0] al;
        int          n, got, cyc;
        al = a & 32'hFFFF_FFE0;
        @(negedge clk);
        #1;
        if (wr) begin
            model[al] = l;
            e.wr = 1'b1; e.addr = al; e.line = l;
            exp_q.push_back(e);
        end
        if (rd) begin
            e.wr = 1'b0; e.addr = al; e.line = model_get(al);
            exp_q.push_back(e);
        end
        n = int'(wr) + int'(rd);
        address_i = a; line_i = l; write_i = wr; read_i = rd;
        got = 0; cyc = 0; lat1 = 0; lat2 = 0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
            if (resp_o) begin
                got++;
                if (got == 1) begin
                    lat1 = cyc;
                    write_i = 1'b0;
                end else begin
                    lat2 = cyc - lat1;
                end
                if (got == n) begin
                    read_i = 1'b0;
                    write_i = 1'b0;
                end
            end else if (scramble && (read_o || write_o)) begin
                address_i = $urandom;
                line_i = rand_line();
            end
        end
        check("txn_complete", got, n);
        if (got < n) begin
            read_i = 1'b0;
            write_i = 1'b0;
            exp_q.delete();
        end
    endtask

    initial begin : driver
        int           l1, l2;
        logic [255:0] p;
        exp_t         e;
        bit           wr, rd;
        int           kind;
        logic [31:0]  a;

        #12;
        check("rst_resp_o", resp_o, 0);
        check("rst_read_o", read_o, 0);
        check("rst_write_o", write_o, 0);
        check("rst_address_o", address_o, 0);
        check("rst_burst_o", burst_o, 0);
        check("rst_line_o", line_o, 0);
        @(negedge clk);
        #1 rst = 1'b1;

        // Read, no gaps
        gap_mode = 0;
        p = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        dram[32'h0000_1220] = p;
        model[32'h0000_1220] = p;
        txn(1'b0, 1'b1, 32'h0000_1234, '0, 1'b0, l1, l2);
        check("t1_latency", l1, 5);

        // Write with a two-cycle gap before beat 2, then read it back
        gap_mode = 2;
        gap_left = 2;
        p = 256'h0123456789ABCDEF_13579BDF02468ACE_FEDCBA9876543210_89ABCDEF01234567;
        txn(1'b1, 1'b0, 32'h8000_00FF, p, 1'b0, l1, l2);
        check("t2_latency", l1, 7);
        check("t2_gap_used", gap_left, 0);
        gap_mode = 0;
        txn(1'b0, 1'b1, 32'h8000_00E0, '0, 1'b0, l1, l2);

        // Simultaneous write and read: write first, read after one idle cycle
        txn(1'b1, 1'b1, 32'h0000_2040, rand_line(), 1'b0, l1, l2);
        check("t3_wr_latency", l1, 5);
        check("t3_rd_latency", l2, 6);

        // Reset in the middle of a read
        @(negedge clk);
        #1;
        e.wr = 1'b0; e.addr = 32'h40; e.line = model_get(32'h40);
        exp_q.push_back(e);
        address_i = 32'h44;
        read_i = 1'b1;
        for (int i = 0; i < 20 && rb < 2; i++) begin
            @(negedge clk);
            #1;
        end
        check("t4_two_beats", rb, 2);
        @(posedge clk);
        #2 rst = 1'b0;
        read_i = 1'b0;
        #1;
        check("t4_read_o", read_o, 0);
        check("t4_address_o", address_o, 0);
        check("t4_resp_o", resp_o, 0);
        check("t4_line_o", line_o, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        p = rand_line();
        dram[32'h40] = p;
        model[32'h40] = p;
        txn(1'b0, 1'b1, 32'h40, '0, 1'b0, l1, l2);
        check("t4_after_latency", l1, 5);

        // Inputs scrambled after acceptance must not disturb the transaction
        txn(1'b1, 1'b0, 32'h0000_3000, rand_line(), 1'b1, l1, l2);
        txn(1'b0, 1'b1, 32'h0000_3010, '0, 1'b1, l1, l2);

        // Random traffic with gaps and spurious resp_i in IDLE/DONE
        gap_mode = 1;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            wr = (kind != 0);
            rd = (kind != 1);
            a = 32'h100 + 32'($urandom_range(0, 7)) * 32 + 32'($urandom_range(0, 31));
            txn(wr, rd, a, rand_line(), (kind != 2) && ($urandom_range(0, 1) == 1), l1, l2);
        end

        gap_mode = 0;
        repeat (5) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
